// File: rtl/serial_mag_comparator.sv
// rtl/serial_mag_comparator.sv - multi-cycle MSB-first digit-serial magnitude comparator
module serial_mag_comparator #(
    parameter int WIDTH      = 16,
    parameter int DIGIT      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start_valid,
    output logic                                 start_ready,
    input  logic [WIDTH-1:0]                     a,
    input  logic [WIDTH-1:0]                     b,
    input  logic                                 is_signed,
    output logic                                 res_valid,
    input  logic                                 res_ready,
    output logic                                 eq,
    output logic                                 lt,
    output logic                                 gt,
    output logic [$clog2(WIDTH/DIGIT+1)-1:0]     cycles
);

    localparam int N  = (DIGIT > 0) ? WIDTH / DIGIT : 1;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] N_C = CW'(N);
    localparam bit EE = (EARLY_EXIT != 0);

    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_mag_comparator: WIDTH must be a positive multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [CW-1:0]     step_q, step_d;
    logic              diff_q, diff_d;
    logic              dgt_q, dgt_d;
    logic              dlt_q, dlt_d;
    logic              eq_q, eq_d;
    logic              lt_q, lt_d;
    logic              gt_q, gt_d;
    logic [CW-1:0]     cycles_q, cycles_d;

    logic [DIGIT-1:0]  dig_a;
    logic [DIGIT-1:0]  dig_b;
    logic [CW-1:0]     step_inc;

    // Next-state, shift datapath and result capture.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        step_d   = step_q;
        diff_d   = diff_q;
        dgt_d    = dgt_q;
        dlt_d    = dlt_q;
        eq_d     = eq_q;
        lt_d     = lt_q;
        gt_d     = gt_q;
        cycles_d = cycles_q;
        dig_a    = a_sh_q[WIDTH-1 -: DIGIT];
        dig_b    = b_sh_q[WIDTH-1 -: DIGIT];
        step_inc = step_q + CW'(1);

        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    // Flipping the sign bit maps two's complement onto
                    // offset binary, so the rest of the path is unsigned.
                    a_sh_d             = a;
                    a_sh_d[WIDTH-1]    = a[WIDTH-1] ^ is_signed;
                    b_sh_d             = b;
                    b_sh_d[WIDTH-1]    = b[WIDTH-1] ^ is_signed;
                    step_d             = '0;
                    diff_d             = 1'b0;
                    dgt_d              = 1'b0;
                    dlt_d              = 1'b0;
                    state_d            = COMPARE;
                end
            end
            COMPARE: begin
                a_sh_d = a_sh_q << DIGIT;
                b_sh_d = b_sh_q << DIGIT;
                step_d = step_inc;
                // Only the most significant differing digit decides.
                if (!diff_q && (dig_a != dig_b)) begin
                    diff_d = 1'b1;
                    dgt_d  = (dig_a > dig_b);
                    dlt_d  = (dig_a < dig_b);
                end
                if ((EE && diff_d) || (step_inc == N_C)) begin
                    eq_d     = !diff_d;
                    gt_d     = dgt_d;
                    lt_d     = dlt_d;
                    cycles_d = step_inc;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            step_q   <= '0;
            diff_q   <= 1'b0;
            dgt_q    <= 1'b0;
            dlt_q    <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
            gt_q     <= 1'b0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            step_q   <= step_d;
            diff_q   <= diff_d;
            dgt_q    <= dgt_d;
            dlt_q    <= dlt_d;
            eq_q     <= eq_d;
            lt_q     <= lt_d;
            gt_q     <= gt_d;
            cycles_q <= cycles_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign eq          = eq_q;
    assign lt          = lt_q;
    assign gt          = gt_q;
    assign cycles      = cycles_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// tb/tb_serial_mag_comparator.sv - directed and random checks of serial_mag_comparator
module tb_serial_mag_comparator;

    typedef struct {
        logic       eq;
        logic       lt;
        logic       gt;
        logic [2:0] cyc;
        int         lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_valid;
    logic        sel;
    logic        is_signed;
    logic        res_ready;
    logic [15:0] a;
    logic [15:0] b;

    logic        sv1, sr1, rv1, eq1, lt1, gt1;
    logic [2:0]  cy1;
    logic        sv2, sr2, rv2, eq2, lt2, gt2;
    logic [2:0]  cy2;
    logic        o_sr, o_rv, o_eq, o_lt, o_gt;
    logic [2:0]  o_cy;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    assign sv1  = start_valid & ~sel;
    assign sv2  = start_valid & sel;
    assign o_sr = sel ? sr2 : sr1;
    assign o_rv = sel ? rv2 : rv1;
    assign o_eq = sel ? eq2 : eq1;
    assign o_lt = sel ? lt2 : lt1;
    assign o_gt = sel ? gt2 : gt1;
    assign o_cy = sel ? cy2 : cy1;

    serial_mag_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(sr1),
        .a(a), .b(b), .is_signed(is_signed), .res_valid(rv1), .res_ready(res_ready),
        .eq(eq1), .lt(lt1), .gt(gt1), .cycles(cy1)
    );

    serial_mag_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(0)) dut_const (
        .clk(clk), .rst_n(rst_n), .start_valid(sv2), .start_ready(sr2),
        .a(a), .b(b), .is_signed(is_signed), .res_valid(rv2), .res_ready(res_ready),
        .eq(eq2), .lt(lt2), .gt(gt2), .cycles(cy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic e, input logic l, input logic g, input int c);
        exp_t r;
        r.eq = e; r.lt = l; r.gt = g; r.cyc = 3'(c); r.lat = c;
        return r;
    endfunction

    // Reference: full-width compare plus position of the first differing nibble.
    function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv,
                                   input logic s, input bit early);
        exp_t        r;
        logic [15:0] x;
        int          k;
        x = av ^ bv;
        k = 4;
        if (early) begin
            for (int i = 0; i < 4; i++) begin
                if (x[4*i +: 4] != 4'h0) k = 4 - i;
            end
        end
        r.eq  = (av == bv);
        r.lt  = s ? ($signed(av) < $signed(bv)) : (av < bv);
        r.gt  = s ? ($signed(av) > $signed(bv)) : (av > bv);
        r.cyc = 3'(k);
        r.lat = k;
        return r;
    endfunction

    task automatic run_cmp(input string tag, input logic [15:0] av, input logic [15:0] bv,
                           input logic s, input exp_t e);
        int   lat;
        logic got;
        exp_t ex;
        @(negedge clk);
        a = av; b = bv; is_signed = s; start_valid = 1'b1;
        sb.push_back(e);
        chk({tag, ".start_ready"}, 32'(o_sr), 32'd1);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        is_signed = 1'($urandom);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            got = o_rv;
        end
        chk({tag, ".res_valid"}, 32'(got), 32'd1);
        if (sb.size() > 0) begin
            ex = sb.pop_front();
            chk({tag, ".eq"}, 32'(o_eq), 32'(ex.eq));
            chk({tag, ".lt"}, 32'(o_lt), 32'(ex.lt));
            chk({tag, ".gt"}, 32'(o_gt), 32'(ex.gt));
            chk({tag, ".cycles"}, 32'(o_cy), 32'(ex.cyc));
            chk({tag, ".latency"}, 32'(lat), 32'(ex.lat));
        end
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rs;
        rst_n = 1'b0; start_valid = 1'b0; sel = 1'b0; is_signed = 1'b0;
        res_ready = 1'b1; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.start_ready", 32'(sr1), 32'd1);
        chk("reset.res_valid", 32'(rv1), 32'd0);
        chk("reset.flags", {29'd0, eq1, lt1, gt1}, 32'd0);
        chk("reset.cycles", 32'(cy1), 32'd0);
        rst_n = 1'b1;

        run_cmp("eq_1234", 16'h1234, 16'h1234, 1'b0, mk(1, 0, 0, 4));
        run_cmp("u_8000_7fff", 16'h8000, 16'h7FFF, 1'b0, mk(0, 0, 1, 1));
        run_cmp("u_1233_1234", 16'h1233, 16'h1234, 1'b0, mk(0, 1, 0, 4));
        run_cmp("s_8000_7fff", 16'h8000, 16'h7FFF, 1'b1, mk(0, 1, 0, 1));
        run_cmp("s_ffff_fffe", 16'hFFFF, 16'hFFFE, 1'b1, mk(0, 0, 1, 4));
        run_cmp("s_ffff_0000", 16'hFFFF, 16'h0000, 1'b1, mk(0, 1, 0, 1));

        @(negedge clk);
        sel = 1'b1;
        run_cmp("ee0_f000_0fff", 16'hF000, 16'h0FFF, 1'b0, mk(0, 0, 1, 4));
        run_cmp("ee0_equal", 16'hABCD, 16'hABCD, 1'b1, mk(1, 0, 0, 4));
        @(negedge clk);
        sel = 1'b0;

        res_ready = 1'b0;
        run_cmp("bp_eq", 16'h1234, 16'h1234, 1'b0, mk(1, 0, 0, 4));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.res_valid", 32'(rv1), 32'd1);
            chk("bp.eq", {29'd0, eq1, lt1, gt1}, 32'd4);
            chk("bp.cycles", 32'(cy1), 32'd4);
            chk("bp.start_ready", 32'(sr1), 32'd0);
            start_valid = ~start_valid;
            a = 16'($urandom);
            b = 16'($urandom);
        end
        @(negedge clk);
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release.start_ready", 32'(sr1), 32'd1);
        chk("bp_release.res_valid", 32'(rv1), 32'd0);
        chk("bp_release.hold_eq", 32'(eq1), 32'd1);
        run_cmp("after_bp", 16'h00FF, 16'h0100, 1'b0, mk(0, 1, 0, 2));

        @(negedge clk);
        a = 16'h1111; b = 16'h1111; is_signed = 1'b0; start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid.start_ready", 32'(sr1), 32'd1);
        chk("rst_mid.res_valid", 32'(rv1), 32'd0);
        chk("rst_mid.flags", {29'd0, eq1, lt1, gt1}, 32'd0);
        chk("rst_mid.cycles", 32'(cy1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_cmp("after_rst", 16'h0001, 16'h0002, 1'b0, mk(0, 1, 0, 4));

        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom);
            rb = ra ^ (16'($urandom_range(0, 15)) << (4 * $urandom_range(0, 3)));
            if (i % 3 == 0) rb = 16'($urandom);
            rs = 1'($urandom);
            run_cmp("rand", ra, rb, rs, model(ra, rb, rs, 1'b1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
